// File: rtl/isp_mem_pkg.sv
// Shared definitions for the line-RAM read path: FSM encoding, default widths and RAM read latency.
// READ_LATENCY follows SDPB_LINE_READER_OCE_PIPE_EN (pipeline read mode when defined).
package isp_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int DEF_AW = 12;
  localparam int DEF_DW = 16;

`ifdef SDPB_LINE_READER_OCE_PIPE_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/sdpb_line_reader_fifo.sv
// Synchronous output buffer for the line reader; power-of-2 depth, count/full/empty status.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module sdpb_line_reader_fifo #(
  parameter  int W     = 17,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sdpb_line_reader.sv
// Read-side controller for the simple-dual-port line RAM: issues port-B reads and streams words out.
// Define SDPB_LINE_READER_OCE_PIPE_EN for a RAM in pipeline read mode (latency 2, ram_oce driven).
module sdpb_line_reader
  import isp_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  output logic [AW-1:0] ram_adb,
  output logic          ram_ceb,
  output logic          ram_oce,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int RL = READ_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [RL-1:0] rd_vld_q, rd_vld_d;
  logic [RL-1:0] rd_last_q, rd_last_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [DW:0]   fifo_rdata;
  logic [CW-1:0] inflight;
  logic [CW:0]   credit_used;
  logic          issue, last_issue, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RL; i++) begin
      inflight = inflight + {{(CW-1){1'b0}}, rd_vld_q[i]};
    end
  end

  // Every read in flight owns a reserved buffer slot, so returning data never overflows.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state_q == ST_ISSUE) && (rem_q != '0) && !fifo_full &&
                       (credit_used < DEPTH_C);
  assign last_issue  = (rem_q == {{AW{1'b0}}, 1'b1});
  assign pop         = m_valid && m_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rd_vld_d     = '0;
    rd_last_d    = '0;
    rd_vld_d[0]  = issue;
    rd_last_d[0] = issue && last_issue;
    for (int i = 1; i < RL; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_last_d[i] = rd_last_q[i-1];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finishing on the final handshake itself puts done right after the last word.
        if ((pop && m_last) || (inflight == '0 && fifo_empty)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

  sdpb_line_reader_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld_q[RL-1]),
    .wdata ({rd_last_q[RL-1], ram_dout}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign ram_adb   = addr_q;
  assign ram_ceb   = issue;
`ifdef SDPB_LINE_READER_OCE_PIPE_EN
  assign ram_oce   = rd_vld_q[0];
`else
  assign ram_oce   = 1'b1;
`endif
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_rdata[DW-1:0];
  assign m_last    = !fifo_empty && fifo_rdata[DW];

endmodule

// File: tb/tb_sdpb_line_reader.sv
// Scoreboard bench for sdpb_line_reader with a behavioural port-B RAM model of the selected latency.
module tb_sdpb_line_reader;
  import isp_mem_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int RL = READ_LATENCY;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [AW-1:0] ram_adb;
  logic          ram_ceb, ram_oce;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last, busy, done;

  always #5 clk = ~clk;

  sdpb_line_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_adb(ram_adb), .ram_ceb(ram_ceb),
    .ram_oce(ram_oce), .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  // Behavioural RAM port B
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ram_q1, ram_q2;
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i) ^ 16'hA5A5;
  always @(posedge clk) begin
    if (ram_ceb) ram_q1 <= mem[ram_adb];
    if (ram_oce) ram_q2 <= ram_q1;
  end
  assign ram_dout = (RL == 2) ? ram_q2 : ram_q1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic fail(input string nm, input int got);
    n_chk++;
    $display("FAIL %s: got %0d, none allowed", nm, got);
  endtask

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] adb_q[$];

  // Monitor / scoreboard
  int   outstanding = 0, pops_this = 0, first_pop = 0, last_pop = 0;
  int   done_cyc = 0, done_cnt = 0, ceb_cnt = 0, mv_cnt = 0;
  logic hold_v = 1'b0;
  logic [DW:0] hold_w = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      outstanding = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, hold_w});
      if (ram_ceb) begin
        ceb_cnt++;
        check("credit", 64'(outstanding < FD), 64'd1);
        if (adb_q.size() > 0) check("ram_adb", ram_adb, adb_q.pop_front());
        else fail("ram_adb_unexpected", int'(ram_adb));
        outstanding++;
      end
      if (m_valid) mv_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) check("word", {m_last, m_data}, exp_q.pop_front());
        else fail("word_unexpected", int'(m_data));
        if (pops_this == 0) first_pop = cyc;
        last_pop = cyc;
        pops_this++;
        outstanding--;
      end
      hold_v = m_valid && !m_ready;
      hold_w = {m_last, m_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Sink ready: 0 = low, 1 = high, 2 = random 30% ready
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = (rdy_mode == 2) ? ($urandom_range(0, 99) < 30) : (rdy_mode == 1);
  end

  int acc_cyc = 0;

  task automatic send(input logic [AW-1:0] a, input logic [AW:0] l, input bit push_exp);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!cmd_ready) fail("cmd_ready_timeout", t);
    if (push_exp) begin
      for (int i = 0; i < int'(l); i++) begin
        logic [AW-1:0] ad;
        ad = a + AW'(i);
        adb_q.push_back(ad);
        exp_q.push_back({(i == int'(l) - 1), DW'(ad) ^ 16'hA5A5});
      end
    end
    pops_this = 0;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(posedge clk); #1; t++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  function automatic logic [63:0] rst_vec();
    return 64'({cmd_ready, ram_adb, ram_ceb, ram_oce, m_valid, m_data, m_last, busy, done});
  endfunction
  localparam logic [34:0] RST_EXP = {1'b1, 12'd0, 1'b0, (RL == 1), 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};

  logic [15:0] t1_data [8] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6,
                               16'hA5A1, 16'hA5A0, 16'hA5A3, 16'hA5A2};
  logic [15:0] t2_data [8] = '{16'hAA59, 16'hAA58, 16'hAA5B, 16'hAA5A,
                               16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
  logic [11:0] t2_addr [8] = '{12'd4092, 12'd4093, 12'd4094, 12'd4095,
                               12'd0, 12'd1, 12'd2, 12'd3};

  initial begin
    #2;
    check("reset_outputs", rst_vec(), 64'(RST_EXP));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: addr 0, len 8, continuous ready
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      adb_q.push_back(AW'(i));
      exp_q.push_back({(i == 7), t1_data[i]});
    end
    send(12'd0, 13'd8, 1'b0);
    wait_done(100);
    check("t1_first_latency", 64'(first_pop - acc_cyc), 64'(2 + RL));
    check("t1_back_to_back", 64'(last_pop - first_pop), 64'd7);
    check("t1_done_after_last", 64'(done_cyc - last_pop), 64'd1);
    check("t1_words_left", 64'(exp_q.size()), 64'd0);

    // 2: address wrap 4092..3
    for (int i = 0; i < 8; i++) begin
      adb_q.push_back(t2_addr[i]);
      exp_q.push_back({(i == 7), t2_data[i]});
    end
    send(12'd4092, 13'd8, 1'b0);
    wait_done(100);
    check("t2_words_left", 64'(exp_q.size()), 64'd0);
    check("t2_addrs_left", 64'(adb_q.size()), 64'd0);

    // 3: random backpressure
    rdy_mode = 2;
    send(12'd100, 13'd16, 1'b1);
    wait_done(1000);
    check("t3_words_left", 64'(exp_q.size()), 64'd0);
    rdy_mode = 1;

    // 4: zero length
    begin
      int c0, v0;
      c0 = ceb_cnt;
      v0 = mv_cnt;
      send(12'd5, 13'd0, 1'b1);
      wait_done(10);
      check("t4_done_cycle", 64'(done_cyc - acc_cyc), 64'd1);
      check("t4_ready_back", {63'(cyc - acc_cyc), cmd_ready}, {63'd2, 1'b1});
      check("t4_no_ceb", 64'(ceb_cnt - c0), 64'd0);
      check("t4_no_valid", 64'(mv_cnt - v0), 64'd0);
    end

    // 5: reset in the middle of a long command
    send(12'd50, 13'd100, 1'b1);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("t5_async_reset", rst_vec(), 64'(RST_EXP));
    exp_q.delete();
    adb_q.delete();
    @(posedge clk); #1;
    check("t5_reset_held", rst_vec(), 64'(RST_EXP));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(12'd10, 13'd5, 1'b1);
    wait_done(100);
    check("t5_words_left", 64'(exp_q.size()), 64'd0);
    check("t5_first_latency", 64'(first_pop - acc_cyc), 64'(2 + RL));

    // Full-RAM read starting mid-array
    send(12'd3000, 13'd4096, 1'b1);
    wait_done(6000);
    check("wrap_words_left", 64'(exp_q.size()), 64'd0);
    check("wrap_addrs_left", 64'(adb_q.size()), 64'd0);
    check("idle_after", {62'd0, cmd_ready, busy}, 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
